// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle for maxpool2x2_stream: upstream pixel beats in, pooled pixel pulses out.
// The slave modport is the pooling stage's view; master is the producer/consumer side.
interface maxpool2x2_stream_if #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 16
);
  logic                          Valid_In;
  logic [DATA_WIDHT*CHANNEL-1:0] Data_In;
  logic [DATA_WIDHT*CHANNEL-1:0] Data_Out;
  logic                          Valid_Out;

  modport slave (
    input  Valid_In,
    input  Data_In,
    output Data_Out,
    output Valid_Out
  );

  modport master (
    output Valid_In,
    output Data_In,
    input  Data_Out,
    input  Valid_Out
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 binary32 max-pool over a raster pixel stream, no backpressure.
// Optional fused ReLU on the pooled result when MAXPOOL_RELU_EN is defined.
module maxpool2x2_stream #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 16,
  parameter int IMG_WIDHT  = 42,
  parameter int IMG_HEIGHT = 42
) (
  input  logic               clk,
  input  logic               rst,
  maxpool2x2_stream_if.slave s
);

  localparam int PIX_W    = DATA_WIDHT * CHANNEL;
  localparam int COL_W    = (IMG_WIDHT > 2) ? $clog2(IMG_WIDHT) : 2;
  localparam int ROW_W    = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = (IMG_WIDHT / 2 > 0) ? IMG_WIDHT / 2 : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]      LB_LIMIT  = COL_W'(LB_DEPTH);
  localparam logic [DATA_WIDHT-1:0] SIGN_MASK = {1'b1, {(DATA_WIDHT-1){1'b0}}};

  // Monotonic unsigned key: larger key means larger float value (NaNs included).
  function automatic logic [DATA_WIDHT-1:0] order_key(input logic [DATA_WIDHT-1:0] x);
    return x[DATA_WIDHT-1] ? ~x : (x | SIGN_MASK);
  endfunction

  // Earlier operand wins ties.
  function automatic logic [DATA_WIDHT-1:0] fmax(input logic [DATA_WIDHT-1:0] first,
                                                 input logic [DATA_WIDHT-1:0] second);
    return (order_key(second) > order_key(first)) ? second : first;
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic [PIX_W-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;

  logic [PIX_W-1:0] line_mem [LB_DEPTH];
  logic [PIX_W-1:0] lb_rd_q;

  logic             accept;
  logic             col_odd;
  logic             row_odd;
  logic [COL_W-1:0] lb_idx;
  logic [LB_AW-1:0] lb_addr;
  logic             lb_in_range;
  logic [PIX_W-1:0] pair_max;
  logic [PIX_W-1:0] pool_max;
  logic [PIX_W-1:0] pool_out;

  // rst is active-low, so a beat only counts while the block is out of reset.
  assign accept      = s.Valid_In & rst;
  assign col_odd     = col_q[0];
  assign row_odd     = row_q[0];
  assign lb_idx      = col_q >> 1;
  assign lb_addr     = lb_idx[LB_AW-1:0];
  assign lb_in_range = (lb_idx < LB_LIMIT);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL; gi++) begin : g_chan
      assign pair_max[gi*DATA_WIDHT +: DATA_WIDHT] =
        fmax(hold_q[gi*DATA_WIDHT +: DATA_WIDHT], s.Data_In[gi*DATA_WIDHT +: DATA_WIDHT]);
      assign pool_max[gi*DATA_WIDHT +: DATA_WIDHT] =
        fmax(lb_rd_q[gi*DATA_WIDHT +: DATA_WIDHT], pair_max[gi*DATA_WIDHT +: DATA_WIDHT]);
`ifdef MAXPOOL_RELU_EN
      assign pool_out[gi*DATA_WIDHT +: DATA_WIDHT] =
        pool_max[gi*DATA_WIDHT + DATA_WIDHT - 1] ? '0 : pool_max[gi*DATA_WIDHT +: DATA_WIDHT];
`else
      assign pool_out[gi*DATA_WIDHT +: DATA_WIDHT] = pool_max[gi*DATA_WIDHT +: DATA_WIDHT];
`endif
    end
  endgenerate

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_odd) begin
        hold_d = s.Data_In;
      end
      if (col_odd && row_odd) begin
        valid_out_d = 1'b1;
        data_out_d  = pool_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Line buffer: the odd-row even-col beat prefetches the upper-row pair max so
  // the RAM read is registered yet ready when the window-closing beat arrives.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd && lb_in_range) begin
      line_mem[lb_addr] <= pair_max;
    end
    if (accept && !col_odd && row_odd && lb_in_range) begin
      lb_rd_q <= line_mem[lb_addr];
    end
  end

  assign s.Data_Out  = data_out_q;
  assign s.Valid_Out = valid_out_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: a 4x4 two-channel instance and a 5x5 one-channel instance.
// Channel 1 of the 4x4 instance carries the sign-flipped channel-0 pixel.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  maxpool2x2_stream_if #(.DATA_WIDHT(32), .CHANNEL(2)) if4 ();
  maxpool2x2_stream_if #(.DATA_WIDHT(32), .CHANNEL(1)) if5 ();

  maxpool2x2_stream #(.DATA_WIDHT(32), .CHANNEL(2), .IMG_WIDHT(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst), .s(if4)
  );
  maxpool2x2_stream #(.DATA_WIDHT(32), .CHANNEL(1), .IMG_WIDHT(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk(clk), .rst(rst), .s(if5)
  );

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   nout = 0;
  logic mon_en = 1'b0;
  logic rst_seen = 1'b1;
  logic [63:0] held4 = '0;
  logic [63:0] held5 = '0;

  logic [63:0] ramp4_exp [4];
  logic [63:0] ramp5_exp [4];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst;
  end

  function automatic logic [31:0] i2f(input int n);
    int          e;
    logic [31:0] m;
    e = 0;
    for (int i = 0; i < 31; i++) if (((n >> i) & 1) != 0) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [63:0] relu64(input logic [63:0] x);
    logic [63:0] r;
    r = x;
`ifdef MAXPOOL_RELU_EN
    if (r[63]) r[63:32] = '0;
    if (r[31]) r[31:0]  = '0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon_step(input int id, input logic v, input logic [63:0] d,
                          input logic [63:0] held_in, output logic [63:0] held_out);
    exp_t e;
    int   n;
    held_out = held_in;
    n = (id == 0) ? q4.size() : q5.size();
    if (v) begin
      if (n == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out dut%0d actual=%h required=no output", id, d);
      end else begin
        if (id == 0) e = q4.pop_front();
        else         e = q5.pop_front();
        nout++;
        $display("out %0d dut%0d data=%h exp=%h cyc=%0d", nout, id, d, e.data, cyc);
        check("out_data", d, e.data);
        check("out_latency", 64'(cyc), 64'(e.due));
        held_out = e.data;
      end
    end else begin
      check("out_hold", d, held_in);
      if (n > 0) begin
        e = (id == 0) ? q4[0] : q5[0];
        if (e.due < cyc) begin
          total++;
          bad++;
          $display("FAIL missing_out dut%0d actual=none required=%h due=%0d", id, e.data, e.due);
          if (id == 0) void'(q4.pop_front());
          else         void'(q5.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        held4 = '0;
        held5 = '0;
      end
      mon_step(0, if4.Valid_Out, if4.Data_Out, held4, held4);
      mon_step(1, if5.Valid_Out, {32'h0, if5.Data_Out}, held5, held5);
    end
  end

  task automatic drive4(input logic [31:0] p, input bit push, input logic [63:0] req);
    @(negedge clk);
    if4.Valid_In = 1'b1;
    if4.Data_In  = {p ^ 32'h80000000, p};
    if (push) q4.push_back('{data: relu64(req), due: cyc + 1});
  endtask

  task automatic drive5(input logic [31:0] p, input bit push, input logic [63:0] req);
    @(negedge clk);
    if5.Valid_In = 1'b1;
    if5.Data_In  = p;
    if (push) q5.push_back('{data: relu64(req), due: cyc + 1});
  endtask

  task automatic idle();
    @(negedge clk);
    if4.Valid_In = 1'b0;
    if5.Valid_In = 1'b0;
    if4.Data_In  = {$urandom, $urandom};
    if5.Data_In  = $urandom;
  endtask

  task automatic ramp4(input bit gaps);
    int k;
    bit done;
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        done = (r % 2 == 1) && (c % 2 == 1);
        drive4(i2f(r * 4 + c + 1), done, ramp4_exp[k]);
        if (done) k++;
        if (gaps) idle();
      end
    end
  endtask

  task automatic tile4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3, input logic [63:0] req);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case ({r[0], c[0]})
          2'b00:   w = w0;
          2'b01:   w = w1;
          2'b10:   w = w2;
          default: w = w3;
        endcase
        drive4(w, (r % 2 == 1) && (c % 2 == 1), req);
      end
    end
  endtask

  task automatic ramp5();
    int k;
    bit done;
    k = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        done = (r % 2 == 1) && (c % 2 == 1) && (r < 4) && (c < 4);
        drive5(i2f(r * 5 + c + 1), done, ramp5_exp[k]);
        if (done) k++;
      end
    end
  endtask

  initial begin
    // {channel1, channel0}; channel 1 is the negated ramp, so its max is the window's first pixel.
    ramp4_exp[0] = {32'hBF800000, 32'h40C00000};
    ramp4_exp[1] = {32'hC0400000, 32'h41000000};
    ramp4_exp[2] = {32'hC1100000, 32'h41600000};
    ramp4_exp[3] = {32'hC1300000, 32'h41800000};
    // 7.0, 9.0, 17.0, 19.0
    ramp5_exp[0] = 64'h40E00000;
    ramp5_exp[1] = 64'h41100000;
    ramp5_exp[2] = 64'h41880000;
    ramp5_exp[3] = 64'h41980000;

    rst          = 1'b0;
    if4.Valid_In = 1'b0;
    if4.Data_In  = '0;
    if5.Valid_In = 1'b0;
    if5.Data_In  = '0;
    repeat (3) @(negedge clk);
    check("reset_valid4", 64'(if4.Valid_Out), 64'h0);
    check("reset_data4", if4.Data_Out, 64'h0);
    check("reset_valid5", 64'(if5.Valid_Out), 64'h0);
    check("reset_data5", {32'h0, if5.Data_Out}, 64'h0);
    rst    = 1'b1;
    mon_en = 1'b1;

    ramp4(1'b0);
    tile4(32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hBF000000, {32'h40400000, 32'hBF000000});
    tile4(32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000, {32'h00000000, 32'h00000000});
    tile4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, {32'h00000000, 32'h80000000});
    idle();
    ramp4(1'b1);
    idle();

    ramp5();
    ramp5();
    idle();
    idle();

    // Mid-frame reset that coincides with the sixth beat: that beat must be dropped.
    for (int p = 1; p <= 5; p++) drive4(i2f(p), 1'b0, '0);
    @(negedge clk);
    rst          = 1'b0;
    if4.Valid_In = 1'b1;
    if4.Data_In  = {i2f(6) ^ 32'h80000000, i2f(6)};
    @(negedge clk);
    rst          = 1'b1;
    if4.Valid_In = 1'b0;
    check("midreset_data4", if4.Data_Out, 64'h0);
    check("midreset_valid4", 64'(if4.Valid_Out), 64'h0);
    idle();
    ramp4(1'b0);

    repeat (6) idle();
    check("q4_drained", 64'(q4.size()), 64'h0);
    check("q5_drained", 64'(q5.size()), 64'h0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
